// File: rtl/preg_free_list_ctrl.sv
// ---------------------------------------------------------------------------
// preg_free_list_ctrl
//   Controller for the rename-stage physical-register free list, which lives
//   in an external multi-write FIFO that does not seed itself on reset.
//   After reset it pushes INIT_COUNT consecutive pregs starting at INIT_START,
//   then grants one preg per cycle to rename and round-robin arbitrates up to
//   NUM_REL release sources onto the FIFO write lanes. The occupancy count is
//   kept locally; the FIFO's empty/full flags are only cross-checked.
//
// Ports
//   clk, reset   clock, synchronous active-high reset
//   alloc_req    rename requests one preg
//   alloc_gnt    request granted this cycle (combinational)
//   alloc_preg   granted preg, passthrough of the FIFO head
//   rel_valid    per-source release request
//   rel_preg     per-source preg being released
//   rel_ready    per-source accept (valid & ready completes a release)
//   fl_wr_en     FIFO write-lane enables
//   fl_wr_data   FIFO write-lane data
//   fl_full      FIFO full flag (checking only)
//   fl_rd_en     FIFO pop
//   fl_rd_data   FIFO head
//   fl_empty     FIFO empty flag (checking only)
//   init_done    high once seeding is finished
//   free_count   number of free pregs currently held in the FIFO
// ---------------------------------------------------------------------------
module preg_free_list_ctrl #(
  parameter int unsigned PREG_WIDTH    = 7,
  parameter int unsigned FL_ADDR_WIDTH = 6,
  parameter int unsigned NUM_WR_WIDTH  = 1,
  parameter int unsigned NUM_REL       = 4,
  parameter int unsigned INIT_START    = 32,
  parameter int unsigned INIT_COUNT    = 32
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic                                           alloc_req,
  output logic                                           alloc_gnt,
  output logic [PREG_WIDTH-1:0]                          alloc_preg,
  input  logic [NUM_REL-1:0]                             rel_valid,
  input  logic [NUM_REL-1:0][PREG_WIDTH-1:0]             rel_preg,
  output logic [NUM_REL-1:0]                             rel_ready,
  output logic [(1<<NUM_WR_WIDTH)-1:0]                   fl_wr_en,
  output logic [(1<<NUM_WR_WIDTH)-1:0][PREG_WIDTH-1:0]   fl_wr_data,
  input  logic                                           fl_full,
  output logic                                           fl_rd_en,
  input  logic [PREG_WIDTH-1:0]                          fl_rd_data,
  input  logic                                           fl_empty,
  output logic                                           init_done,
  output logic [FL_ADDR_WIDTH:0]                         free_count
);

  localparam int unsigned DEPTH  = 1 << FL_ADDR_WIDTH;
  localparam int unsigned NUM_WR = 1 << NUM_WR_WIDTH;
  localparam int unsigned CNT_W  = FL_ADDR_WIDTH + 1;
  localparam int unsigned LANE_W = NUM_WR_WIDTH + 1;
  localparam int unsigned RR_W   = (NUM_REL > 1) ? $clog2(NUM_REL) : 1;
  localparam int unsigned SCAN_W = RR_W + 1;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e                               state_q;
  state_e                               state_d;
  logic [CNT_W-1:0]                     init_cnt_q;
  logic [RR_W-1:0]                      rr_ptr_q;
  logic [RR_W-1:0]                      rr_ptr_d;

  logic [CNT_W-1:0]                     init_left;
  logic [LANE_W-1:0]                    init_n;
  logic [NUM_WR-1:0]                    init_lane_en;
  logic [NUM_WR-1:0][PREG_WIDTH-1:0]    init_lane_data;

  logic                                 run_active;
  logic                                 grant_alloc;

  logic [CNT_W-1:0]                     room;
  logic [LANE_W-1:0]                    slots;
  logic [LANE_W-1:0]                    grant_cnt;
  logic [SCAN_W-1:0]                    scan;
  logic [SCAN_W-1:0]                    rr_next_scan;
  logic [RR_W-1:0]                      idx;
  logic [RR_W-1:0]                      last_idx;
  logic [NUM_REL-1:0]                   rel_grant;
  logic [NUM_WR-1:0]                    rel_lane_en;
  logic [NUM_WR-1:0][PREG_WIDTH-1:0]    rel_lane_data;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: leave INIT on the cycle that pushes the last seed.
  // With INIT_COUNT=0 the comparison holds immediately, giving one INIT cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: begin
        if ((init_cnt_q + CNT_W'(init_n)) >= CNT_W'(INIT_COUNT)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  // Seed lanes: up to NUM_WR consecutive pregs per cycle.
  always_comb begin
    init_left      = CNT_W'(INIT_COUNT) - init_cnt_q;
    init_n         = (init_left >= CNT_W'(NUM_WR)) ? LANE_W'(NUM_WR) : LANE_W'(init_left);
    init_lane_en   = '0;
    init_lane_data = '0;
    for (int unsigned l = 0; l < NUM_WR; l++) begin
      if (LANE_W'(l) < init_n) begin
        init_lane_en[l]   = 1'b1;
        init_lane_data[l] = PREG_WIDTH'(INIT_START + 32'(init_cnt_q) + l);
      end
    end
  end

  // Allocation decision; feeds both the pop and the release slot budget.
  always_comb begin
    run_active  = (state_q == ST_RUN) && !reset;
    grant_alloc = run_active && alloc_req && (free_count != '0);
  end

  // Release arbitration. A same-cycle pop reserves one entry so that the
  // pop+push pair can never bring the count to DEPTH.
  always_comb begin
    room = CNT_W'(DEPTH) - free_count;
    if (grant_alloc && (room != '0)) begin
      room = room - CNT_W'(1);
    end
    slots = (room >= CNT_W'(NUM_WR)) ? LANE_W'(NUM_WR) : LANE_W'(room);

    rel_grant     = '0;
    rel_lane_en   = '0;
    rel_lane_data = '0;
    grant_cnt     = '0;
    last_idx      = rr_ptr_q;
    scan          = '0;
    idx           = '0;
    for (int unsigned j = 0; j < NUM_REL; j++) begin
      scan = {1'b0, rr_ptr_q} + SCAN_W'(j);
      if (scan >= SCAN_W'(NUM_REL)) begin
        scan = scan - SCAN_W'(NUM_REL);
      end
      idx = scan[RR_W-1:0];
      // Granted sources fill lanes 0..k-1 in scan order.
      if (run_active && rel_valid[idx] && (grant_cnt < slots)) begin
        rel_grant[idx]                          = 1'b1;
        rel_lane_en[grant_cnt[LANE_W-2:0]]      = 1'b1;
        rel_lane_data[grant_cnt[LANE_W-2:0]]    = rel_preg[idx];
        grant_cnt                               = grant_cnt + LANE_W'(1);
        last_idx                                = idx;
      end
    end

    rr_next_scan = {1'b0, last_idx} + SCAN_W'(1);
    if (rr_next_scan >= SCAN_W'(NUM_REL)) begin
      rr_next_scan = '0;
    end
    rr_ptr_d = rr_next_scan[RR_W-1:0];
  end

  // Outputs: everything quiet during reset; INIT drives seeds, RUN drives
  // allocation and releases.
  always_comb begin
    init_done  = 1'b0;
    alloc_gnt  = 1'b0;
    fl_rd_en   = 1'b0;
    rel_ready  = '0;
    fl_wr_en   = '0;
    fl_wr_data = '0;
    alloc_preg = fl_rd_data;
    if (!reset) begin
      case (state_q)
        ST_INIT: begin
          fl_wr_en   = init_lane_en;
          fl_wr_data = init_lane_data;
        end
        ST_RUN: begin
          init_done  = 1'b1;
          alloc_gnt  = grant_alloc;
          fl_rd_en   = grant_alloc;
          rel_ready  = rel_grant;
          fl_wr_en   = rel_lane_en;
          fl_wr_data = rel_lane_data;
        end
        default: ;
      endcase
    end
  end

  // Seed counter, occupancy count and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      init_cnt_q <= '0;
      rr_ptr_q   <= '0;
      free_count <= '0;
    end else if (state_q == ST_INIT) begin
      init_cnt_q <= init_cnt_q + CNT_W'(init_n);
      free_count <= free_count + CNT_W'(init_n);
    end else begin
      free_count <= free_count + CNT_W'(grant_cnt) - CNT_W'(grant_alloc);
      if (grant_cnt != '0) begin
        rr_ptr_q <= rr_ptr_d;
      end
    end
  end

  // Local occupancy must track the FIFO's own flags once running.
  a_empty_tracks: assert property (@(posedge clk) disable iff (reset)
    (state_q == ST_RUN) |-> (fl_empty == (free_count == '0)));
  a_full_tracks: assert property (@(posedge clk) disable iff (reset)
    (state_q == ST_RUN) |-> (fl_full == (free_count == CNT_W'(DEPTH))));
  a_no_write_in_reset: assert property (@(posedge clk)
    reset |-> (fl_wr_en == '0));

endmodule

// File: tb/tb_preg_free_list_ctrl.sv
// Bench for preg_free_list_ctrl: emulates the free-list FIFO, keeps a
// behavioural model of which pregs must be free (a queue), and checks every
// cycle plus hand-computed expectations for the directed scenarios.
module tb_preg_free_list_ctrl;

  localparam int PW    = 7;
  localparam int NR    = 4;
  localparam int NW    = 2;
  localparam int DEPTH = 64;
  localparam int IS    = 32;
  localparam int IC    = 32;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 alloc_req = 1'b0;
  logic                 alloc_gnt;
  logic [PW-1:0]        alloc_preg;
  logic [NR-1:0]        rel_valid = '0;
  logic [NR-1:0][PW-1:0] rel_preg = '0;
  logic [NR-1:0]        rel_ready;
  logic [NW-1:0]        fl_wr_en;
  logic [NW-1:0][PW-1:0] fl_wr_data;
  logic                 fl_full = 1'b0;
  logic                 fl_rd_en;
  logic [PW-1:0]        fl_rd_data = '0;
  logic                 fl_empty = 1'b1;
  logic                 init_done;
  logic [6:0]           free_count;

  preg_free_list_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .alloc_req  (alloc_req),
    .alloc_gnt  (alloc_gnt),
    .alloc_preg (alloc_preg),
    .rel_valid  (rel_valid),
    .rel_preg   (rel_preg),
    .rel_ready  (rel_ready),
    .fl_wr_en   (fl_wr_en),
    .fl_wr_data (fl_wr_data),
    .fl_full    (fl_full),
    .fl_rd_en   (fl_rd_en),
    .fl_rd_data (fl_rd_data),
    .fl_empty   (fl_empty),
    .init_done  (init_done),
    .free_count (free_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: what the free list must contain, seeding progress, RR pointer.
  bit m_run   = 1'b0;
  bit m_known = 1'b0;
  int m_seeded = 0;
  int m_ptr    = 0;
  int exp_q[$];
  // FIFO emulation, filled from what the DUT actually writes.
  int fifo_q[$];

  // Observed DUT outputs, sampled mid-cycle.
  logic                  o_gnt, o_rd_en, o_done;
  logic [PW-1:0]         o_preg;
  logic [NR-1:0]         o_ready;
  logic [NW-1:0]         o_wr_en;
  logic [NW-1:0][PW-1:0] o_wr_data;
  logic [6:0]            o_free;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: apply inputs, compare against the model, take the edge,
  // then advance model and FIFO.
  task automatic cycle(input bit r, input bit req, input logic [NR-1:0] v,
                       input logic [NR-1:0][PW-1:0] p);
    bit          e_gnt;
    bit          e_done;
    bit [NR-1:0] e_ready;
    bit [NW-1:0] e_en;
    int          e_data[NW];
    int          grants[$];
    int          room, slots, n, s;

    reset = r; alloc_req = req; rel_valid = v; rel_preg = p;
    #1;
    e_gnt = 0; e_done = 0; e_ready = '0; e_en = '0;
    e_data[0] = 0; e_data[1] = 0; n = 0;
    if (!r) begin
      if (!m_run) begin
        n = (IC - m_seeded < NW) ? IC - m_seeded : NW;
        for (int l = 0; l < n; l++) begin
          e_en[l]   = 1'b1;
          e_data[l] = IS + m_seeded + l;
        end
      end else begin
        e_done = 1;
        e_gnt  = req && (exp_q.size() > 0);
        room   = DEPTH - exp_q.size() - (e_gnt ? 1 : 0);
        if (room < 0) room = 0;
        slots  = (room < NW) ? room : NW;
        for (int j = 0; j < NR; j++) begin
          s = (m_ptr + j) % NR;
          if (v[s] && grants.size() < slots) begin
            e_ready[s] = 1'b1;
            e_en[grants.size()]   = 1'b1;
            e_data[grants.size()] = int'(p[s]);
            grants.push_back(s);
          end
        end
      end
    end

    o_gnt = alloc_gnt; o_rd_en = fl_rd_en; o_done = init_done; o_preg = alloc_preg;
    o_ready = rel_ready; o_wr_en = fl_wr_en; o_wr_data = fl_wr_data; o_free = free_count;

    check("init_done", o_done, e_done);
    check("alloc_gnt", o_gnt, e_gnt);
    check("fl_rd_en", o_rd_en, e_gnt);
    check("rel_ready", o_ready, e_ready);
    check("fl_wr_en", o_wr_en, e_en);
    check("wr_data0", o_wr_data[0], e_data[0]);
    check("wr_data1", o_wr_data[1], e_data[1]);
    if (e_gnt) check("alloc_preg", o_preg, exp_q[0]);
    if (!r && m_known) check("free_count", o_free, exp_q.size());

    @(posedge clk);
    #1;
    if (r) begin
      m_run = 0; m_seeded = 0; m_ptr = 0; m_known = 1;
      exp_q.delete();
      fifo_q.delete();
    end else begin
      if (!m_run) begin
        for (int l = 0; l < n; l++) exp_q.push_back(IS + m_seeded + l);
        m_seeded += n;
        if (m_seeded >= IC) m_run = 1;
      end else begin
        if (e_gnt) void'(exp_q.pop_front());
        foreach (grants[g]) exp_q.push_back(int'(p[grants[g]]));
        if (grants.size() > 0) m_ptr = (grants[grants.size()-1] + 1) % NR;
      end
      if (o_rd_en) begin
        check("fifo_pop_nonempty", int'(fifo_q.size() > 0), 1);
        if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      end
      for (int l = 0; l < NW; l++) begin
        if (o_wr_en[l]) begin
          check("fifo_push_room", int'(fifo_q.size() < DEPTH), 1);
          if (fifo_q.size() < DEPTH) fifo_q.push_back(int'(o_wr_data[l]));
        end
      end
    end
    fl_rd_data = (fifo_q.size() > 0) ? PW'(fifo_q[0]) : '0;
    fl_empty   = (fifo_q.size() == 0);
    fl_full    = (fifo_q.size() == DEPTH);
  endtask

  initial begin
    logic [NR-1:0][PW-1:0] pp;

    // T1: reset, 16 seeding cycles of pairs, then RUN.
    cycle(1, 0, '0, '0);
    check("t1_rst_wr_en", o_wr_en, 0);
    for (int c = 0; c < 16; c++) begin
      cycle(0, 0, '0, '0);
      check("t1_seed_lane0", o_wr_data[0], 32 + 2*c);
      check("t1_seed_lane1", o_wr_data[1], 33 + 2*c);
      check("t1_not_done", o_done, 0);
    end
    cycle(0, 0, '0, '0);
    check("t1_done", o_done, 1);
    check("t1_free", o_free, 32);

    // T2: three back-to-back allocations.
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, '0, '0);
      check("t2_gnt", o_gnt, 1);
      check("t2_preg", o_preg, 32 + i);
    end
    cycle(0, 0, '0, '0);
    check("t2_free", o_free, 29);

    // T3: four releases over two lanes, round robin.
    cycle(0, 0, 4'b1111, {7'd4, 7'd3, 7'd2, 7'd1});
    check("t3_c1_ready", o_ready, 4'b0011);
    check("t3_c1_lane0", o_wr_data[0], 1);
    check("t3_c1_lane1", o_wr_data[1], 2);
    cycle(0, 0, 4'b1100, {7'd4, 7'd3, 7'd2, 7'd1});
    check("t3_c2_ready", o_ready, 4'b1100);
    check("t3_c2_lane0", o_wr_data[0], 3);
    check("t3_c2_lane1", o_wr_data[1], 4);
    cycle(0, 0, '0, '0);
    check("t3_free", o_free, 33);

    // Fill to 63.
    for (int c = 0; c < 15; c++) begin
      pp = '0;
      pp[0] = PW'(64 + 2*c);
      pp[1] = PW'(65 + 2*c);
      cycle(0, 0, 4'b0011, pp);
    end

    // T4: at 63 a pop blocks the release; next cycle it is accepted.
    pp = '0; pp[0] = 7'd100;
    cycle(0, 1, 4'b0001, pp);
    check("t4_free63", o_free, 63);
    check("t4_gnt", o_gnt, 1);
    check("t4_ready_blocked", o_ready, 0);
    cycle(0, 0, 4'b0001, pp);
    check("t4_free62", o_free, 62);
    check("t4_ready_accept", o_ready, 4'b0001);

    // Boundary: one slot left, pointer at source 1.
    pp = '0; pp[0] = 7'd102; pp[1] = 7'd101;
    cycle(0, 0, 4'b0011, pp);
    check("full_minus1_free", o_free, 63);
    check("full_minus1_ready", o_ready, 4'b0010);
    check("full_minus1_lane0", o_wr_data[0], 101);
    pp = '0; pp[0] = 7'd103;
    cycle(0, 0, 4'b0001, pp);
    check("full_free", o_free, 64);
    check("full_ready", o_ready, 0);
    cycle(0, 1, 4'b0001, pp);
    check("full_pop_gnt", o_gnt, 1);
    check("full_pop_ready", o_ready, 0);

    // Drain to empty.
    for (int c = 0; c < 63; c++) cycle(0, 1, '0, '0);

    // T5: empty list, release is not bypassed.
    pp = '0; pp[0] = 7'd5;
    cycle(0, 1, 4'b0001, pp);
    check("t5_free0", o_free, 0);
    check("t5_gnt0", o_gnt, 0);
    check("t5_ready", o_ready, 4'b0001);
    cycle(0, 1, '0, '0);
    check("t5_gnt1", o_gnt, 1);
    check("t5_preg5", o_preg, 5);

    // T6: reset with traffic in flight, then re-seed.
    pp = '0; pp[0] = 7'd10; pp[1] = 7'd11; pp[2] = 7'd12; pp[3] = 7'd13;
    cycle(0, 1, 4'b0011, pp);
    cycle(0, 1, 4'b1111, pp);
    cycle(1, 1, 4'b1111, pp);
    check("t6_rst_gnt", o_gnt, 0);
    check("t6_rst_ready", o_ready, 0);
    check("t6_rst_wr_en", o_wr_en, 0);
    check("t6_rst_done", o_done, 0);
    cycle(0, 1, 4'b1111, pp);
    check("t6_seed_en", o_wr_en, 2'b11);
    check("t6_seed_lane0", o_wr_data[0], 32);
    check("t6_seed_lane1", o_wr_data[1], 33);
    check("t6_seed_ready", o_ready, 0);
    check("t6_seed_gnt", o_gnt, 0);
    check("t6_free0", o_free, 0);
    for (int c = 0; c < 15; c++) cycle(0, 1, 4'b1111, pp);

    // Mixed traffic checked against the model.
    for (int i = 0; i < 60; i++) begin
      for (int s = 0; s < NR; s++) pp[s] = PW'((i*13 + s*29) % 128);
      cycle(0, (i % 3) != 0, NR'((i*5 + (i >> 2)) % 16), pp);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
